// File: rtl/key_pkg.sv
// Shared types and constants for the five-key debouncer.
package key_pkg;

    localparam int unsigned NUM_KEYS = 5;

    typedef enum logic [1:0] {
        StUp,
        StWaitDown,
        StDown,
        StWaitUp
    } key_fsm_e;

    localparam logic [2:0] TONE_NONE = 3'd0;
    localparam logic [2:0] TONE_K0   = 3'd1;
    localparam logic [2:0] TONE_K1   = 3'd2;
    localparam logic [2:0] TONE_K2   = 3'd3;
    localparam logic [2:0] TONE_K3   = 3'd4;
    localparam logic [2:0] TONE_K4   = 3'd5;

    // Lowest-index pressing key wins, so it is tested last.
    function automatic logic [2:0] tone_encode(input logic [NUM_KEYS-1:0] press);
        logic [2:0] tone;
        tone = TONE_NONE;
        if (press[4]) tone = TONE_K4;
        if (press[3]) tone = TONE_K3;
        if (press[2]) tone = TONE_K2;
        if (press[1]) tone = TONE_K1;
        if (press[0]) tone = TONE_K0;
        return tone;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key: 2-flop synchronizer, four-state debounce FSM, stability counter,
// registered level and press/release pulses.
module debounce_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic press_next_o
);

    localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    key_fsm_e        fsm_q;
    logic [CntW-1:0] cnt_q;
    logic            state_q;
    logic            press_q;
    logic            release_q;
    logic            key_s;

    assign key_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            fsm_q     <= StUp;
            cnt_q     <= '0;
            state_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (fsm_q)
                StUp: begin
                    if (!key_s) fsm_q <= StWaitDown;
                end
                StWaitDown: begin
                    if (key_s) begin
                        fsm_q <= StUp;
                        cnt_q <= '0;
                    end else if (cnt_q == CntMax) begin
                        fsm_q   <= StDown;
                        cnt_q   <= '0;
                        state_q <= 1'b0;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDown: begin
                    if (key_s) fsm_q <= StWaitUp;
                end
                StWaitUp: begin
                    if (!key_s) begin
                        fsm_q <= StDown;
                        cnt_q <= '0;
                    end else if (cnt_q == CntMax) begin
                        fsm_q     <= StUp;
                        cnt_q     <= '0;
                        state_q   <= 1'b1;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: fsm_q <= StUp;
            endcase
        end
    end

    // Lets the top register tone_sel in the same cycle that press_o rises.
    assign press_next_o = (fsm_q == StWaitDown) && !key_s && (cnt_q == CntMax);

    assign state_o   = state_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Five independent debounce channels plus the latched tone selector.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [2:0]          tone_sel
);

    logic [NUM_KEYS-1:0] press_next;
    logic [2:0]          tone_q;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .key_i       (key[i]),
            .state_o     (key_state[i]),
            .press_o     (key_press[i]),
            .release_o   (key_release[i]),
            .press_next_o(press_next[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tone_q <= TONE_NONE;
        end else if (|press_next) begin
            tone_q <= tone_encode(press_next);
        end
    end

    assign tone_sel = tone_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_CYCLES = 4.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] key = 5'b11111;
    logic [4:0] key_state;
    logic [4:0] key_press;
    logic [4:0] key_release;
    logic [2:0] tone_sel;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    typedef struct {
        int         cyc;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] state;
        logic [2:0] tone;
    } exp_t;

    exp_t sb[$];

    key_debounce #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .tone_sel   (tone_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Pin change applied at this negedge is first sampled on the next edge T;
    // the debounced event appears on edge T+6.
    task automatic expect_evt(input logic [4:0] p, input logic [4:0] r,
                              input logic [4:0] s, input logic [2:0] t);
        exp_t e;
        e.cyc = edge_n + 7;
        e.press = p;
        e.rel = r;
        e.state = s;
        e.tone = t;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_outputs(input string name, input logic [4:0] s, input logic [2:0] t);
        chk({name, ".state"}, int'(key_state), int'(s));
        chk({name, ".press"}, int'(key_press), 0);
        chk({name, ".release"}, int'(key_release), 0);
        chk({name, ".tone"}, int'(tone_sel), int'(t));
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < edge_n) begin
            chk("missed_event", 0, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (!rst && (|key_press || |key_release)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", int'({key_press, key_release}), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("evt.cycle", edge_n, e.cyc);
                chk("evt.press", int'(key_press), int'(e.press));
                chk("evt.release", int'(key_release), int'(e.rel));
                chk("evt.state", int'(key_state), int'(e.state));
                chk("evt.tone", int'(tone_sel), int'(e.tone));
            end
        end
    end

    initial begin
        idle(3);
        chk_outputs("reset", 5'b11111, 3'd0);
        rst = 1'b0;
        idle(2);

        // Clean press of key 0, then release.
        key = 5'b11110;
        expect_evt(5'b00001, 5'b00000, 5'b11110, 3'd1);
        idle(12);
        chk_outputs("held_k0", 5'b11110, 3'd1);
        key = 5'b11111;
        expect_evt(5'b00000, 5'b00001, 5'b11111, 3'd1);
        idle(12);
        chk_outputs("released_k0", 5'b11111, 3'd1);

        // Three-cycle glitch on key 2.
        key = 5'b11011;
        idle(3);
        key = 5'b11111;
        idle(12);
        chk_outputs("bounce_k2", 5'b11111, 3'd1);

        // Keys 1 and 3 together; key 1 wins tone priority.
        key = 5'b10101;
        expect_evt(5'b01010, 5'b00000, 5'b10101, 3'd2);
        idle(12);
        chk_outputs("held_k1k3", 5'b10101, 3'd2);
        key = 5'b11111;
        expect_evt(5'b00000, 5'b01010, 5'b11111, 3'd2);
        idle(12);
        chk_outputs("released_k1k3", 5'b11111, 3'd2);

        // Reset lands while key 4 is still being qualified.
        key = 5'b01111;
        idle(3);
        rst = 1'b1;
        key = 5'b11111;
        idle(1);
        rst = 1'b0;
        idle(12);
        chk_outputs("rst_mid_wait", 5'b11111, 3'd0);

        // Key 3 held across reset deassertion.
        key = 5'b10111;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        expect_evt(5'b01000, 5'b00000, 5'b10111, 3'd4);
        idle(12);
        chk_outputs("held_thru_rst", 5'b10111, 3'd4);
        key = 5'b11111;
        expect_evt(5'b00000, 5'b01000, 5'b11111, 3'd4);
        idle(12);
        chk_outputs("final", 5'b11111, 3'd4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the number of consecutive stable synchronized samples needed to accept a level change (legal range >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock. All logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port key, input, 5 bits: raw push-button pins, active-low (0 = pressed), asynchronous to clk, may bounce.
REQ-005 SHALL have port key_state, output, 5 bits: debounced level, active-low, same encoding as key.
REQ-006 SHALL have port key_press, output, 5 bits: one-cycle pulse per bit when a debounced press is accepted.
REQ-007 SHALL have port key_release, output, 5 bits: one-cycle pulse per bit when a debounced release is accepted.
REQ-008 SHALL have port tone_sel, output, 3 bits: latched code of the most recently pressed key (0 = none, 1..5 = key[0]..key[4]).

Function
REQ-009 Each key bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Each key SHALL have an independent FSM with four states: UP, WAIT_DOWN, DOWN, WAIT_UP.
REQ-011 Transitions SHALL be:
- UP -> WAIT_DOWN on a synchronized 0.
- DOWN -> WAIT_UP on a synchronized 1.
- In WAIT_x, the per-key counter increments while the sample keeps the new level.
- If the sample reverts, return to the prior stable state and clear the counter.
- When the counter reaches DEBOUNCE_CYCLES-1 with the new level still present, enter DOWN/UP and clear the counter.
REQ-012 Per-key counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter never wraps, because it is cleared at every state exit.
REQ-013 key_state, key_press and key_release SHALL be registered.
REQ-014 A clean pin change SHALL cause key_state to change, and key_press/key_release to pulse for exactly one cycle, DEBOUNCE_CYCLES+2 clocks after the first clk edge that samples the new pin level.
REQ-015 A pulse SHALL never repeat while a key is held; a pulse-free glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no output change.
REQ-016 tone_sel SHALL update in the same cycle any key_press bit is high, to the lowest-index pressing key +1.
REQ-017 tone_sel SHALL hold its value otherwise; releases never change it.
REQ-018 Simultaneous press events SHALL each pulse their own key_press bit; tone_sel priority is lowest index.
REQ-019 Keys SHALL be fully independent: activity on one key never alters another key's FSM or counter.

Reset
REQ-020 On rst, all FSMs SHALL go to UP, counters to 0, and synchronizer flops to 1.
REQ-021 On rst, outputs SHALL be: key_state = 5'b11111, key_press = 0, key_release = 0, tone_sel = 0.
REQ-022 A rst asserted mid-WAIT SHALL abort the pending change; no pulse is emitted for it.
REQ-023 A key physically held through reset release SHALL be re-debounced and produce a normal key_press after DEBOUNCE_CYCLES+2 clocks.

Structure
REQ-024 Shared package key_pkg SHALL hold:
- NUM_KEYS = 5.
- The FSM state enum (UP, WAIT_DOWN, DOWN, WAIT_UP).
- tone_sel code constants (TONE_NONE = 0, TONE_K0..TONE_K4 = 1..5).
REQ-025 Sub-module debounce_channel SHALL contain one synchronizer, one FSM and one counter, and be instantiated NUM_KEYS times.
REQ-026 The top level SHALL contain only the instances, the tone_sel priority encoder and its register.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Clean press: key = 5'b11110 from edge T, held -> key_press = 5'b00001 for exactly one cycle at T+6, key_state[0] = 0 from T+6, tone_sel = 1.
REQ-028 Bounce: key[2] low for 3 cycles, then high -> key_press stays 0, key_state stays 5'b11111, tone_sel unchanged.
REQ-029 Simultaneous press: key = 5'b10101 at edge T, held -> key_press = 5'b01010 for one cycle at T+6, tone_sel = 2.
REQ-030 Release: after the first scenario, key -> 5'b11111 -> key_release = 5'b00001 for one cycle 6 clocks later, key_state = 5'b11111, tone_sel stays 1.
REQ-031 Reset mid-WAIT: press key[4]; assert rst 3 clocks later for 1 cycle, then release the pin -> all outputs at reset values, and no key_press pulse at any time.
REQ-032 Held through reset: key[3] low across rst deassertion -> key_press = 5'b01000 exactly 6 clocks after the first edge with rst low, tone_sel = 4.
